// File: rtl/std_nbdcache_valid_dirty_arb.sv
// Valid/dirty store for the non-blocking data cache. Requesters share one
// single-port SRAM. It is cleared after reset and on request.

module std_nbdcache_vd_sram #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter type         impl_in_t  = logic,
  parameter type         impl_out_t = logic,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                 clk_i,
  input  impl_in_t             impl_i,
  output impl_out_t            impl_o,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0]         mem_q [NumWords];
  logic [DataWidth-1:0]         rdata_q;
  logic [BeWidth*ByteWidth-1:0] laneMask;
  logic [DataWidth-1:0]         bitMask;
  logic                         unusedImpl;

  assign unusedImpl = ^impl_i;
  assign impl_o     = '0;

  always_comb begin
    laneMask = '0;
    for (int b = 0; b < BeWidth; b++) begin
      laneMask[b*ByteWidth +: ByteWidth] = {ByteWidth{be_i[b]}};
    end
  end

  assign bitMask = laneMask[DataWidth-1:0];

  // The read register only updates on a read, so clears never disturb data in flight.
  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        mem_q[addr_i] <= (mem_q[addr_i] & ~bitMask) | (wdata_i & bitMask);
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

module std_nbdcache_valid_dirty_arb #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned Latency   = 1,
  parameter type         impl_in_t  = logic,
  parameter type         impl_out_t = logic,
  localparam int unsigned BeWidth      = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned AddrWidth    = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned PortIdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  impl_in_t                            impl_i,
  output impl_out_t                           impl_o,
  input  logic [NumPorts-1:0]                 req_i,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
  output logic [NumPorts-1:0]                 gnt_o,
  output logic [NumPorts-1:0]                 rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o,
  input  logic                                flush_i,
  output logic                                flush_ack_o,
  output logic                                init_done_o
);

  typedef enum logic [1:0] {
    StInit,
    StReady,
    StFlush
  } state_e;

  state_e                                state_q, state_d;
  logic [AddrWidth-1:0]                  cnt_q, cnt_d;
  logic [PortIdxWidth-1:0]               rr_q, rr_d;
  logic                                  flushAck_q, flushAck_d;

  logic [NumPorts-1:0]                   gnt;
  logic                                  gntValid;
  logic [PortIdxWidth-1:0]               gntIdx;
  logic [PortIdxWidth-1:0]               cand;

  logic                                  sramReq;
  logic                                  sramWe;
  logic [AddrWidth-1:0]                  sramAddr;
  logic [DataWidth-1:0]                  sramWdata;
  logic [BeWidth-1:0]                    sramBe;
  logic [DataWidth-1:0]                  sramRdata;

  logic [Latency-1:0]                    rdVld_q;
  logic [Latency-1:0][PortIdxWidth-1:0]  rdPort_q;
  logic                                  retVld;
  logic [PortIdxWidth-1:0]               retPort;
  logic [DataWidth-1:0]                  retData;
  logic [NumPorts-1:0]                   rvalid;
  logic [NumPorts-1:0][DataWidth-1:0]    holdData_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      rr_q       <= '0;
      flushAck_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      flushAck_q <= flushAck_d;
    end
  end

  // INIT and FLUSH sweep zeros through every entry; READY round-robins the requesters.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    flushAck_d = 1'b0;
    gnt        = '0;
    gntValid   = 1'b0;
    gntIdx     = '0;
    cand       = '0;
    sramReq    = 1'b0;
    sramWe     = 1'b0;
    sramAddr   = cnt_q;
    sramWdata  = '0;
    sramBe     = '1;
    unique case (state_q)
      StInit, StFlush: begin
        sramReq = 1'b1;
        sramWe  = 1'b1;
        if (cnt_q == AddrWidth'(NumWords - 1)) begin
          state_d    = StReady;
          cnt_d      = '0;
          flushAck_d = (state_q == StFlush);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReady: begin
        if (flush_i) begin
          state_d = StFlush;
        end else begin
          for (int i = 0; i < NumPorts; i++) begin
            cand = PortIdxWidth'((32'(rr_q) + 32'(i)) % NumPorts);
            if (!gntValid && req_i[cand]) begin
              gntValid = 1'b1;
              gntIdx   = cand;
            end
          end
          if (gntValid) begin
            gnt[gntIdx] = 1'b1;
            rr_d        = (32'(gntIdx) == NumPorts - 1) ? '0 : gntIdx + 1'b1;
            sramReq     = 1'b1;
            sramWe      = we_i[gntIdx];
            sramAddr    = addr_i[gntIdx];
            sramWdata   = wdata_i[gntIdx];
            sramBe      = be_i[gntIdx];
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  assign gnt_o       = gnt;
  assign init_done_o = (state_q == StReady);
  assign flush_ack_o = flushAck_q;

  std_nbdcache_vd_sram #(
    .NumWords   (NumWords),
    .DataWidth  (DataWidth),
    .ByteWidth  (ByteWidth),
    .impl_in_t  (impl_in_t),
    .impl_out_t (impl_out_t)
  ) i_sram (
    .clk_i   (clk_i),
    .impl_i  (impl_i),
    .impl_o  (impl_o),
    .req_i   (sramReq),
    .we_i    (sramWe),
    .addr_i  (sramAddr),
    .wdata_i (sramWdata),
    .be_i    (sramBe),
    .rdata_o (sramRdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdVld_q  <= '0;
      rdPort_q <= '0;
    end else begin
      rdVld_q[0]  <= gntValid & ~sramWe;
      rdPort_q[0] <= gntIdx;
      for (int s = 1; s < int'(Latency); s++) begin
        rdVld_q[s]  <= rdVld_q[s-1];
        rdPort_q[s] <= rdPort_q[s-1];
      end
    end
  end

  // The SRAM supplies one cycle of latency; the rest is a plain data delay line.
  if (Latency > 1) begin : genDelay
    logic [Latency-2:0][DataWidth-1:0] delay_q;
    always_ff @(posedge clk_i) begin
      delay_q[0] <= sramRdata;
      for (int s = 1; s < int'(Latency) - 1; s++) begin
        delay_q[s] <= delay_q[s-1];
      end
    end
    assign retData = delay_q[Latency-2];
  end else begin : genNoDelay
    assign retData = sramRdata;
  end

  assign retVld  = rdVld_q[Latency-1];
  assign retPort = rdPort_q[Latency-1];

  always_comb begin
    rvalid = '0;
    if (retVld) begin
      rvalid[retPort] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      holdData_q <= '0;
    end else begin
      for (int k = 0; k < NumPorts; k++) begin
        if (rvalid[k]) begin
          holdData_q[k] <= retData;
        end
      end
    end
  end

  always_comb begin
    rdata_o = holdData_q;
    for (int k = 0; k < NumPorts; k++) begin
      if (rvalid[k]) begin
        rdata_o[k] = retData;
      end
    end
  end

  assign rvalid_o = rvalid;

endmodule

// File: tb/tb_std_nbdcache_valid_dirty_arb.sv
// Bench for std_nbdcache_valid_dirty_arb: reference model of the clear sweeps,
// the round-robin grant and memory contents, plus a per-port read scoreboard.

module tb_std_nbdcache_valid_dirty_arb;

  localparam int NumWords  = 1024;
  localparam int DataWidth = 128;
  localparam int ByteWidth = 8;
  localparam int NumPorts  = 2;
  localparam int Latency   = 2;
  localparam int BeWidth   = 16;
  localparam int AddrWidth = 10;

  typedef struct {
    logic [DataWidth-1:0] data;
    int                   due;
  } rdEntry_t;

  logic                               clk = 1'b0;
  logic                               rst_n;
  logic                               implIn;
  logic                               unusedImplOut;
  logic [NumPorts-1:0]                req, we, gnt, rvalid;
  logic [NumPorts-1:0][AddrWidth-1:0] addr;
  logic [NumPorts-1:0][DataWidth-1:0] wdata, rdata;
  logic [NumPorts-1:0][BeWidth-1:0]   be;
  logic                               flush, flushAck, initDone;

  int                   mState;
  int                   mCnt;
  int                   mRr;
  logic                 mAck;
  logic [DataWidth-1:0] refMem [NumWords];
  rdEntry_t             sb [NumPorts][$];
  logic [DataWidth-1:0] lastData [NumPorts];
  int                   cyc;
  int                   ackSeen;
  int                   checks;
  int                   failures;

  always #5 clk = ~clk;

  std_nbdcache_valid_dirty_arb #(
    .NumWords  (NumWords),
    .DataWidth (DataWidth),
    .ByteWidth (ByteWidth),
    .NumPorts  (NumPorts),
    .Latency   (Latency)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .impl_i      (implIn),
    .impl_o      (unusedImplOut),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .be_i        (be),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .flush_i     (flush),
    .flush_ack_o (flushAck),
    .init_done_o (initDone)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_gnt"}, 128'(gnt), 128'(0));
    checkOutput({tag, "_rvalid"}, 128'(rvalid), 128'(0));
    checkOutput({tag, "_init_done"}, 128'(initDone), 128'(0));
    checkOutput({tag, "_flush_ack"}, 128'(flushAck), 128'(0));
    checkOutput({tag, "_rdata0"}, rdata[0], 128'(0));
    checkOutput({tag, "_rdata1"}, rdata[1], 128'(0));
  endtask

  task automatic resetModel();
    mState = 0;
    mCnt   = 0;
    mRr    = 0;
    mAck   = 1'b0;
    for (int k = 0; k < NumPorts; k++) begin
      sb[k].delete();
      lastData[k] = '0;
    end
  endtask

  // One clock cycle: inputs are already set at the falling edge.
  task automatic applyStimulus();
    logic [NumPorts-1:0] expGnt;
    logic                found;
    logic                expV;
    int                  p;
    rdEntry_t            e;
    #1;
    expGnt = '0;
    found  = 1'b0;
    if (mState == 1 && !flush) begin
      for (int i = 0; i < NumPorts; i++) begin
        p = (mRr + i) % NumPorts;
        if (!found && req[p]) begin
          found     = 1'b1;
          expGnt[p] = 1'b1;
        end
      end
    end
    checkOutput("gnt", 128'(gnt), 128'(expGnt));
    checkOutput("init_done", 128'(initDone), 128'(mState == 1));
    checkOutput("flush_ack", 128'(flushAck), 128'(mAck));
    if (flushAck) ackSeen++;
    for (int k = 0; k < NumPorts; k++) begin
      expV = (sb[k].size() > 0) && (sb[k][0].due == cyc);
      if (expV) begin
        lastData[k] = sb[k][0].data;
        void'(sb[k].pop_front());
      end
      checkOutput($sformatf("rvalid[%0d]", k), 128'(rvalid[k]), 128'(expV));
      checkOutput($sformatf("rdata[%0d]", k), rdata[k], lastData[k]);
    end
    mAck = 1'b0;
    if (mState == 0 || mState == 2) begin
      refMem[mCnt] = '0;
      if (mCnt == NumWords - 1) begin
        mAck   = (mState == 2);
        mState = 1;
        mCnt   = 0;
      end else begin
        mCnt++;
      end
    end else if (flush) begin
      mState = 2;
    end else begin
      for (int k = 0; k < NumPorts; k++) begin
        if (expGnt[k]) begin
          mRr = (k + 1) % NumPorts;
          if (we[k]) begin
            for (int b = 0; b < BeWidth; b++) begin
              if (be[k][b]) refMem[addr[k]][b*ByteWidth +: ByteWidth] = wdata[k][b*ByteWidth +: ByteWidth];
            end
          end else begin
            e.data = refMem[addr[k]];
            e.due  = cyc + Latency;
            sb[k].push_back(e);
          end
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req   = '0;
    we    = '0;
    flush = 1'b0;
    repeat (n) applyStimulus();
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    ackSeen  = 0;
    rst_n    = 1'b0;
    implIn   = 1'b0;
    req      = '0;
    we       = '0;
    addr     = '0;
    wdata    = '0;
    be       = '0;
    flush    = 1'b0;
    resetModel();

    repeat (2) @(negedge clk);
    req = 2'b11;
    #1 checkReset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Power-up sweep with requests pending: nothing may be granted.
    addr[0] = 10'd1;
    addr[1] = 10'd2;
    n = 0;
    while (!initDone && n < 1100) begin
      applyStimulus();
      n++;
    end
    checkOutput("init_cycles", 128'(n), 128'(1024));

    $display("[TB] single read");
    req = 2'b01; we = 2'b00; addr[0] = 10'd5;
    applyStimulus();
    idle(4);

    $display("[TB] byte-masked write then read");
    req = 2'b10; we = 2'b10; addr[1] = 10'd7; wdata[1] = '1; be[1] = 16'h0001;
    applyStimulus();
    we = 2'b00;
    applyStimulus();
    idle(4);

    $display("[TB] both ports streaming");
    req = 2'b11; we = 2'b00; addr[0] = 10'd7; addr[1] = 10'd5;
    repeat (6) applyStimulus();
    idle(3);

    $display("[TB] random traffic");
    repeat (60) begin
      req = 2'($urandom_range(0, 3));
      we  = 2'($urandom_range(0, 3));
      for (int k = 0; k < NumPorts; k++) begin
        addr[k]  = 10'($urandom_range(0, 15));
        wdata[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
        be[k]    = 16'($urandom());
      end
      applyStimulus();
    end
    idle(4);

    $display("[TB] flush with read in flight");
    req = 2'b01; we = 2'b01; addr[0] = 10'd3; be[0] = '1;
    wdata[0] = 128'h0123_4567_89AB_CDEF_DEAD_BEEF_CAFE_F00D;
    applyStimulus();
    we = 2'b00;
    applyStimulus();
    flush = 1'b1; req = 2'b11;
    applyStimulus();
    ackSeen = 0;
    n = 0;
    while (mState != 1 && n < 1100) begin
      flush = (mState == 2 && mCnt < 1000);
      req   = 2'b11;
      applyStimulus();
      n++;
    end
    idle(3);
    checkOutput("flush_ack_count", 128'(ackSeen), 128'(1));
    req = 2'b01; addr[0] = 10'd3;
    applyStimulus();
    idle(4);

    $display("[TB] reset in the middle of a flush");
    flush = 1'b1;
    applyStimulus();
    flush = 1'b0;
    n = 0;
    while (!(mState == 2 && mCnt == 500) && n < 1100) begin
      applyStimulus();
      n++;
    end
    req = 2'b11;
    #2 rst_n = 1'b0;
    #1 checkReset("mid_flush");
    resetModel();
    ackSeen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req = '0;
    n = 0;
    while (!initDone && n < 1100) begin
      applyStimulus();
      n++;
    end
    checkOutput("reinit_cycles", 128'(n), 128'(1024));
    checkOutput("reinit_ack_count", 128'(ackSeen), 128'(0));
    req = 2'b10; addr[1] = 10'd3;
    applyStimulus();
    req = 2'b01; addr[0] = 10'd7;
    applyStimulus();
    idle(4);
    checkOutput("sb_drained", 128'(sb[0].size() + sb[1].size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/std_nbdcache_valid_dirty_arb.md
STD_NBDCACHE_VALID_DIRTY_ARB -- requirements
Module: std_nbdcache_valid_dirty_arb

Interface
REQ-001 The block SHALL have parameter NumWords, default 1024, number of valid/dirty entries (>=2).
REQ-002 The block SHALL have parameter DataWidth, default 128, entry width in bits.
REQ-003 The block SHALL have parameter ByteWidth, default 8, bits per byte-enable lane; BeWidth = ceil(DataWidth/ByteWidth), AddrWidth = clog2(NumWords).
REQ-004 The block SHALL have parameter NumPorts, default 2, number of requesters (1..4).
REQ-005 The block SHALL have parameter Latency, default 1, grant-to-rdata cycles (1..3).
REQ-006 The block SHALL have parameter types impl_in_t / impl_out_t, default logic, passed to the SRAM macro.
REQ-007 The block SHALL have port clk_i, input, 1, the single clock.
REQ-008 The block SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-009 The block SHALL have port impl_i, input, impl_in_t, forwarded to the SRAM; impl_o, output, impl_out_t, driven from the SRAM.
REQ-010 The block SHALL have port req_i, input, NumPorts, per-port request.
REQ-011 The block SHALL have port we_i, input, NumPorts, per-port write enable.
REQ-012 The block SHALL have port addr_i, input, NumPorts x AddrWidth, per-port address.
REQ-013 The block SHALL have port wdata_i, input, NumPorts x DataWidth, and be_i, input, NumPorts x BeWidth.
REQ-014 The block SHALL have port gnt_o, output, NumPorts, per-port grant.
REQ-015 The block SHALL have port rvalid_o, output, NumPorts, and rdata_o, output, NumPorts x DataWidth.
REQ-016 The block SHALL have port flush_i, input, 1, clear-all request; flush_ack_o, output, 1; init_done_o, output, 1.

Function
REQ-017 The block SHALL implement FSM states INIT, READY, FLUSH around one single-port SRAM of NumWords x DataWidth, SRAM latency 1.
REQ-018 In INIT and FLUSH the block SHALL write all-zero data with all byte enables to address cnt, cnt incrementing 0..NumWords-1, one write per cycle.
REQ-019 When cnt = NumWords-1 is written the block SHALL go to READY next cycle; cnt SHALL reset to 0.
REQ-020 init_done_o SHALL be 1 only in READY.
REQ-021 flush_ack_o SHALL pulse 1 for exactly one cycle, the first READY cycle after FLUSH (not after INIT).
REQ-022 flush_i sampled high in READY SHALL move to FLUSH next cycle and no port SHALL be granted that cycle; flush_i in INIT or FLUSH SHALL be ignored.
REQ-023 gnt_o SHALL be all-zero outside READY; in READY at most one bit SHALL be set, only for a port with req_i high, combinationally.
REQ-024 Arbitration SHALL be round-robin: grant the first requesting port at or after pointer rr; after a grant to port k, rr SHALL become (k+1) mod NumPorts; rr unchanged when nothing granted.
REQ-025 A granted write SHALL update only enabled byte lanes and SHALL NOT produce rvalid_o.
REQ-026 A granted read SHALL assert rvalid_o[k] for one cycle exactly Latency cycles after the grant cycle, with rdata_o[k] = entry content as of the grant cycle.
REQ-027 The read return path SHALL be a Latency-deep pipeline of (valid, port id); back-to-back reads SHALL return one per cycle in grant order.
REQ-028 Reads in flight when FLUSH starts SHALL complete normally with pre-flush data.
REQ-029 rdata_o[k] SHALL hold its last value when rvalid_o[k] is low; rdata_o of non-target ports SHALL be unchanged.
REQ-030 Simultaneous flush_i and req_i in READY: flush wins per REQ-022; requester SHALL retry.

Reset
REQ-031 On rst_ni low, asynchronously: state = INIT, cnt = 0, rr = 0, return pipeline valids = 0, rvalid_o = 0, gnt_o = 0, flush_ack_o = 0, init_done_o = 0, rdata_o = 0.
REQ-032 Reset asserted mid-FLUSH or mid-read SHALL discard all in-flight reads and restart INIT from address 0; no flush_ack_o SHALL follow.

Verification
REQ-033 Reset release, NumWords=1024 -> init_done_o rises exactly 1024 cycles later (cycle 1025), gnt_o zero throughout.
REQ-034 After init, port 0 reads addr 5, Latency=2 -> rvalid_o[0]=1 two cycles after grant, rdata_o[0]=0.
REQ-035 Port 1 writes addr 7 data 0xFF..FF be=0x0001, then reads -> rdata_o[1]=0x00..00FF.
REQ-036 Both ports request continuously, NumPorts=2 -> grants alternate 0,1,0,1; rr toggles each cycle.
REQ-037 Write addr 3 nonzero, read issued, flush_i same cycle after -> read returns old data, flush_ack_o pulses once after 1024 FLUSH cycles, re-read of addr 3 returns 0.
REQ-038 rst_ni low at FLUSH cnt=500 -> outputs at reset values immediately, INIT restarts at 0, no flush_ack_o.
